tff_trace_decoder: RTL and testbench

Receiving end of the two-T-flip-flop state machine (TA = A^x, TB = ~A&x). The block samples the machine's {A,B} state stream each valid cycle, recovers the input bit x that produced each transition, and checks every transition against the machine's next-state equations. It flags illegal transitions and goes to a fault state after repeated errors. It sits beside the state machine as a monitor/decoder for bench and on-chip checking.

---
 rtl/tff_trace_decoder_pkg.sv | 15 +
 rtl/sat_counter.sv | 32 +++
 rtl/tff_trace_decoder.sv | 124 ++++++++++++
 tb/tb_tff_trace_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tff_trace_decoder_pkg.sv
// Shared types and the T-flip-flop machine's next-state rule for the trace decoder.
package tff_trace_decoder_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StTrack = 2'b01,
        StFault = 2'b10
    } state_e;

    // B toggles when TB = ~A & x.
    function automatic logic predict_b(input logic ap, input logic bp, input logic x);
        return bp ^ (~ap & x);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up counter with synchronous clear; saturates at all-ones or wraps, selected by sat.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         Clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic         sat,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(sat && (&cnt))) begin
            cnt_d = cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/tff_trace_decoder.sv
// Monitors the {A,B} stream of the two-TFF machine, recovers x and flags illegal transitions.
module tff_trace_decoder
    import tff_trace_decoder_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MAX_ERR    = 3,
    parameter bit          CHECK_INIT = 1'b1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             A,
    input  logic             B,
    input  logic             resync,
    output logic             x_rec,
    output logic             x_valid,
    output logic             err,
    output logic             fault,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    // An error seen while consec holds this value is the MAX_ERR-th in a row.
    localparam logic [CNT_W-1:0] ConsecLast = CNT_W'(MAX_ERR - 1);

    state_e           state_q, state_d;
    logic [1:0]       prev_q, prev_d;
    logic             x_rec_d, x_valid_d, err_d;
    logic             err_inc, bit_inc, consec_inc, consec_clr;
    logic [CNT_W-1:0] consec_q;

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        x_rec_d    = x_rec;
        x_valid_d  = 1'b0;
        err_d      = 1'b0;
        err_inc    = 1'b0;
        bit_inc    = 1'b0;
        consec_inc = 1'b0;
        consec_clr = 1'b0;
        if (resync) begin
            state_d    = StIdle;
            consec_clr = 1'b1;
        end else if (in_valid) begin
            unique case (state_q)
                StIdle: begin
                    prev_d  = {A, B};
                    state_d = StTrack;
                    if (CHECK_INIT && (A || B)) begin
                        err_d      = 1'b1;
                        err_inc    = 1'b1;
                        consec_inc = 1'b1;
                    end
                end
                StTrack: begin
                    x_rec_d   = A;
                    x_valid_d = 1'b1;
                    bit_inc   = 1'b1;
                    prev_d    = {A, B};
                    if (B != predict_b(prev_q[1], prev_q[0], A)) begin
                        err_d      = 1'b1;
                        err_inc    = 1'b1;
                        consec_inc = 1'b1;
                        if (consec_q >= ConsecLast) begin
                            state_d = StFault;
                        end
                    end else begin
                        consec_clr = 1'b1;
                    end
                end
                StFault: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            prev_q  <= 2'b00;
            x_rec   <= 1'b0;
            x_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            x_rec   <= x_rec_d;
            x_valid <= x_valid_d;
            err     <= err_d;
        end
    end

    assign fault = (state_q == StFault);

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .Clk (Clk),
        .rst (rst),
        .inc (err_inc),
        .clr (1'b0),
        .sat (1'b1),
        .cnt (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .Clk (Clk),
        .rst (rst),
        .inc (bit_inc),
        .clr (1'b0),
        .sat (1'b0),
        .cnt (bit_cnt)
    );

    sat_counter #(.W(CNT_W)) u_consec_cnt (
        .Clk (Clk),
        .rst (rst),
        .inc (consec_inc),
        .clr (consec_clr),
        .sat (1'b1),
        .cnt (consec_q)
    );

endmodule

// File: tb/tb_tff_trace_decoder.sv
// Directed and random traces checked against a behavioural model of the two-TFF machine.
module tb_tff_trace_decoder;

    localparam int MaxErr = 3;
    localparam int ModeIdle = 0;
    localparam int ModeTrack = 1;
    localparam int ModeFault = 2;

    logic       Clk;
    logic       rst;
    logic       in_valid;
    logic       A;
    logic       B;
    logic       resync;
    logic       x_rec;
    logic       x_valid;
    logic       err;
    logic       fault;
    logic [7:0] err_cnt;
    logic [7:0] bit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int mode;
    int pa, pb;
    int m_errc, m_bitc, m_consec;
    int m_xv, m_err, m_x;

    tff_trace_decoder #(
        .CNT_W      (8),
        .MAX_ERR    (MaxErr),
        .CHECK_INIT (1'b1)
    ) dut (
        .Clk      (Clk),
        .rst      (rst),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .resync   (resync),
        .x_rec    (x_rec),
        .x_valid  (x_valid),
        .err      (err),
        .fault    (fault),
        .err_cnt  (err_cnt),
        .bit_cnt  (bit_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Full next state of the observed machine: TA = A^x, TB = ~A&x.
    function automatic int tff_next(input int a, input int b, input int x);
        int ta, tb;
        ta = a ^ x;
        tb = (a == 0 && x == 1) ? 1 : 0;
        return ((a ^ ta) << 1) | (b ^ tb);
    endfunction

    task automatic model_reset();
        mode = ModeIdle;
        pa = 0; pb = 0;
        m_errc = 0; m_bitc = 0; m_consec = 0;
        m_xv = 0; m_err = 0; m_x = 0;
    endtask

    task automatic model_err();
        m_err = 1;
        if (m_errc < 255) m_errc++;
        m_consec++;
    endtask

    task automatic model_step(input int v, input int a, input int b, input int rs);
        m_xv = 0;
        m_err = 0;
        if (rs != 0) begin
            mode = ModeIdle;
            m_consec = 0;
        end else if (v != 0) begin
            if (mode == ModeIdle) begin
                if (a != 0 || b != 0) model_err();
                pa = a; pb = b;
                mode = ModeTrack;
            end else if (mode == ModeTrack) begin
                m_xv = 1;
                m_x = a;
                m_bitc = (m_bitc + 1) % 256;
                if (tff_next(pa, pb, a) != ((a << 1) | b)) begin
                    model_err();
                    if (m_consec >= MaxErr) mode = ModeFault;
                end else begin
                    m_consec = 0;
                end
                pa = a; pb = b;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".x_valid"}, 32'(x_valid), 32'(m_xv));
        check({tag, ".err"}, 32'(err), 32'(m_err));
        check({tag, ".fault"}, 32'(fault), 32'(mode == ModeFault));
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_errc));
        check({tag, ".bit_cnt"}, 32'(bit_cnt), 32'(m_bitc));
        if (m_xv != 0) check({tag, ".x_rec"}, 32'(x_rec), 32'(m_x));
    endtask

    task automatic step(input string tag, input int v, input int a, input int b, input int rs);
        @(negedge Clk);
        in_valid = v[0];
        A = a[0];
        B = b[0];
        resync = rs[0];
        @(posedge Clk);
        #1;
        model_step(v, a, b, rs);
        compare_all(tag);
    endtask

    task automatic sample(input string tag, input int ab);
        step(tag, 1, (ab >> 1) & 1, ab & 1, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".x_rec"}, 32'(x_rec), 0);
        check({tag, ".x_valid"}, 32'(x_valid), 0);
        check({tag, ".err"}, 32'(err), 0);
        check({tag, ".fault"}, 32'(fault), 0);
        check({tag, ".err_cnt"}, 32'(err_cnt), 0);
        check({tag, ".bit_cnt"}, 32'(bit_cnt), 0);
    endtask

    initial begin
        int legal_seq[6];
        int nxt, x, v, rs;
        legal_seq = '{0, 3, 3, 1, 2, 0};
        rst = 1'b0;
        in_valid = 1'b0;
        A = 1'b0;
        B = 1'b0;
        resync = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_zero("reset");
        @(negedge Clk);
        rst = 1'b1;

        // Legal trace
        foreach (legal_seq[i]) sample("legal", legal_seq[i]);
        check("legal.bits", 32'(bit_cnt), 5);
        check("legal.errs", 32'(err_cnt), 0);

        // Single bad transitions then a clearing legal one
        step("rs1", 0, 0, 0, 1);
        sample("bad", 0);
        sample("bad", 2);
        sample("bad", 3);
        sample("bad", 1);
        check("bad.errs", 32'(err_cnt), 2);
        check("bad.fault", 32'(fault), 0);

        // Three consecutive errors drive the FSM to FAULT
        step("rs2", 0, 0, 0, 1);
        sample("flt", 0);
        sample("flt", 2);
        sample("flt", 3);
        sample("flt", 2);
        check("flt.fault", 32'(fault), 1);
        sample("flt_ign", 0);
        sample("flt_ign", 3);
        step("flt_rs", 0, 0, 0, 1);
        check("flt.cleared", 32'(fault), 0);

        // Bad initial state, then a legal transition
        sample("init", 1);
        sample("init", 2);
        sample("init", 0);

        // Gaps and resync colliding with a valid sample
        step("rs3", 0, 0, 0, 1);
        sample("gap", 0);
        repeat (3) step("gap_idle", 0, 1, 0, 0);
        sample("gap", 3);
        step("rs_valid", 1, 1, 1, 1);
        sample("after_rs", 0);
        sample("after_rs", 3);

        // Asynchronous reset between clock edges
        step("rs4", 0, 0, 0, 1);
        sample("arst", 0);
        sample("arst", 3);
        sample("arst", 2);
        sample("arst", 1);
        @(negedge Clk);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        check_zero("arst_mid");
        #1 rst = 1'b1;
        model_reset();
        sample("arst_post", 0);
        sample("arst_post", 3);

        // Random traces, mostly legal, with gaps, corruptions and resyncs
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 9) != 0) ? 1 : 0;
            rs = ($urandom_range(0, 39) == 0 ||
                  (mode == ModeFault && $urandom_range(0, 3) == 0)) ? 1 : 0;
            x = $urandom_range(0, 1);
            if (mode == ModeTrack) begin
                nxt = tff_next(pa, pb, x);
                if ($urandom_range(0, 9) < 3) nxt = $urandom_range(0, 3);
            end else begin
                nxt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 0;
            end
            step("rand", v, (nxt >> 1) & 1, nxt & 1, rs);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
